// File: rtl/sram_wait_ctrl.sv
// Word-addressed data SRAM behind a single-outstanding req/ready handshake with a programmable wait-state count.
// Optional per-lane write masking is enabled by defining SRAM_BYTE_WRITE_EN.
module sram_wait_ctrl #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned BASE_ADDR   = 1024,
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     write_data,
`ifdef SRAM_BYTE_WRITE_EN
  input  logic [DATA_W/8-1:0]   byte_en,
`endif
  output logic [DATA_W-1:0]     read_data,
  output logic                  ready,
  output logic                  freeze,
  output logic                  range_err
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned LSB_W = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam int unsigned SPAN  = DEPTH * NB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              op_wr;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [NB-1:0]     be_q;

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  idx;
  logic              err;
  logic              commit;
  logic              wr_commit;

  // Addresses below the window wrap to a huge offset and fall out of range.
  always_comb begin
    off       = addr_q - ADDR_W'(BASE_ADDR);
    idx       = IDX_W'(off >> LSB_W);
    err       = (off >= ADDR_W'(SPAN)) | ((off & ADDR_W'(NB - 1)) != '0);
    commit    = (state == ACCESS) && (cnt == '0);
    wr_commit = commit & op_wr & ~err;
  end

  assign freeze = (wr_en | rd_en) & ~ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      read_data <= '0;
      ready     <= 1'b0;
      range_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready     <= 1'b0;
          range_err <= 1'b0;
          if (wr_en | rd_en) begin
            op_wr   <= wr_en;
            addr_q  <= address;
            wdata_q <= write_data;
`ifdef SRAM_BYTE_WRITE_EN
            be_q    <= byte_en;
`else
            be_q    <= '1;
`endif
            cnt     <= CNT_W'(WAIT_CYCLES - 1);
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            if (!op_wr) read_data <= err ? '0 : mem[idx];
            ready     <= 1'b1;
            range_err <= err;
            state     <= DONE;
          end
        end
        DONE: begin
          ready     <= 1'b0;
          range_err <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A reset asserted on the commit edge blocks the array write.
  always_ff @(posedge clk) begin
    if (rst_n && wr_commit) begin
      for (int i = 0; i < int'(NB); i++) begin
        if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_wait_ctrl.sv
// Directed bench for sram_wait_ctrl at default parameters (WAIT_CYCLES=3, window 1024..1279).
module tb_sram_wait_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  byte_en;
  logic [31:0] read_data;
  logic        ready;
  logic        freeze;
  logic        range_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] rd;
  logic        re;
  int          fc;

  always #5 clk = ~clk;

  sram_wait_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
`ifdef SRAM_BYTE_WRITE_EN
    .byte_en    (byte_en),
`endif
    .read_data  (read_data),
    .ready      (ready),
    .freeze     (freeze),
    .range_err  (range_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full handshake; returns load data, error flag and number of freeze cycles seen.
  task automatic access(input bit w, input bit r, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, output logic [31:0] rdata, output logic rerr,
                        output int fcycles);
    bit got;
    got     = 1'b0;
    fcycles = 0;
    rdata   = '0;
    rerr    = 1'b0;
    @(posedge clk); #1;
    wr_en = w; rd_en = r; address = a; write_data = d; byte_en = be;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (ready) begin
        got   = 1'b1;
        rdata = read_data;
        rerr  = range_err;
        check("freeze_in_done", 32'(freeze), 32'd0);
      end else if (freeze) begin
        fcycles++;
      end
    end
    if (!got) check("ready_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    check("ready_pulse", 32'(ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    address = '0; write_data = '0; byte_en = 4'hf;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_read_data", read_data, 32'h0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_range_err", 32'(range_err), 32'd0);
    check("rst_freeze", 32'(freeze), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic write/read with wait states
    access(1, 0, 32'd1024, 32'hDEADBEEF, 4'hf, rd, re, fc);
    check("wr_freeze_cycles", 32'(fc), 32'd4);
    check("wr_err", 32'(re), 32'd0);
    access(0, 1, 32'd1024, 32'h0, 4'hf, rd, re, fc);
    check("rd_1024", rd, 32'hDEADBEEF);
    check("rd_1024_err", 32'(re), 32'd0);
    check("rd_freeze_cycles", 32'(fc), 32'd4);

    // Window boundaries
    access(1, 0, 32'd1276, 32'h600DF00D, 4'hf, rd, re, fc);
    check("wr_1276_err", 32'(re), 32'd0);
    access(0, 1, 32'd1276, 32'h0, 4'hf, rd, re, fc);
    check("rd_1276", rd, 32'h600DF00D);
    access(0, 1, 32'd1280, 32'h0, 4'hf, rd, re, fc);
    check("rd_1280_err", 32'(re), 32'd1);
    check("rd_1280_data", rd, 32'h0);
    access(1, 0, 32'd1280, 32'hBAD0BAD0, 4'hf, rd, re, fc);
    check("wr_1280_err", 32'(re), 32'd1);
    access(1, 0, 32'd1023, 32'hBAD1BAD1, 4'hf, rd, re, fc);
    check("wr_1023_err", 32'(re), 32'd1);
    access(1, 0, 32'd1026, 32'hBAD2BAD2, 4'hf, rd, re, fc);
    check("wr_1026_err", 32'(re), 32'd1);
    access(0, 1, 32'd1023, 32'h0, 4'hf, rd, re, fc);
    check("rd_1023_err", 32'(re), 32'd1);
    access(0, 1, 32'd1276, 32'h0, 4'hf, rd, re, fc);
    check("rd_1276_kept", rd, 32'h600DF00D);
    access(0, 1, 32'd1024, 32'h0, 4'hf, rd, re, fc);
    check("rd_1024_kept", rd, 32'hDEADBEEF);

    // Simultaneous enables act as a write
    access(1, 1, 32'd1028, 32'h12345678, 4'hf, rd, re, fc);
    check("wrrd_data_held", rd, 32'hDEADBEEF);
    check("wrrd_err", 32'(re), 32'd0);
    access(0, 1, 32'd1028, 32'h0, 4'hf, rd, re, fc);
    check("rd_1028", rd, 32'h12345678);

    // Reset in the 2nd ACCESS cycle abandons the write
    access(1, 0, 32'd1032, 32'hCAFEF00D, 4'hf, rd, re, fc);
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1032; write_data = 32'h0; byte_en = 4'hf;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_read_data", read_data, 32'h0);
    access(0, 1, 32'd1032, 32'h0, 4'hf, rd, re, fc);
    check("rd_1032_after_abort", rd, 32'hCAFEF00D);

    // Reset on the commit edge also blocks the write
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1032; write_data = 32'h55555555;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; wr_en = 1'b0;
    @(negedge clk);
    check("commit_rst_ready", 32'(ready), 32'd0);
    access(0, 1, 32'd1032, 32'h0, 4'hf, rd, re, fc);
    check("rd_1032_after_commit_rst", rd, 32'hCAFEF00D);

`ifdef SRAM_BYTE_WRITE_EN
    access(1, 0, 32'd1036, 32'hAABBCCDD, 4'hf, rd, re, fc);
    access(1, 0, 32'd1036, 32'h11223344, 4'b0101, rd, re, fc);
    access(0, 1, 32'd1036, 32'h0, 4'h0, rd, re, fc);
    check("be_0101", rd, 32'hAA22CC44);
    access(1, 0, 32'd1036, 32'h99999999, 4'b0000, rd, re, fc);
    check("be_0000_err", 32'(re), 32'd0);
    access(0, 1, 32'd1036, 32'h0, 4'hf, rd, re, fc);
    check("be_0000", rd, 32'hAA22CC44);
`else
    access(1, 0, 32'd1036, 32'hAABBCCDD, 4'h0, rd, re, fc);
    access(0, 1, 32'd1036, 32'h0, 4'h0, rd, re, fc);
    check("full_word_write", rd, 32'hAABBCCDD);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
